// File: rtl/instr_rx_n_if.sv
// Bus bundle for the UART instruction receiver: serial line in, byte strobe,
// instruction valid/ready holding register and status pulses out.
interface instr_rx_n_if #(
  parameter int INSTR_BYTES = 2
);
  logic                       i_rx_serial;
  logic                       i_instr_ready;
  logic                       o_byte_dv;
  logic [7:0]                 o_byte;
  logic                       o_instr_valid;
  logic [8*INSTR_BYTES-1:0]   o_instr;
  logic                       o_frame_err;
  logic                       o_timeout;
  logic                       o_overrun;
  logic                       o_busy;

  // master is the receiver producing instructions, slave is the consumer side
  modport master (
    input  i_rx_serial, i_instr_ready,
    output o_byte_dv, o_byte, o_instr_valid, o_instr,
           o_frame_err, o_timeout, o_overrun, o_busy
  );

  modport slave (
    output i_rx_serial, i_instr_ready,
    input  o_byte_dv, o_byte, o_instr_valid, o_instr,
           o_frame_err, o_timeout, o_overrun, o_busy
  );
endinterface

// File: rtl/instr_rx_n.sv
// 8N1 UART receiver that assembles INSTR_BYTES little-endian bytes into one
// instruction word, with timeout resync, framing-error discard and overrun flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line high, waiting for a synchronised start edge
// START   | half-bit wait, re-check start bit (reject glitches)
// DATA    | sample 8 data bits LSB first, one per bit period
// STOP    | sample stop bit; commit byte or flag framing error
// CLEANUP | single settle cycle before returning to IDLE
module instr_rx_n #(
  parameter int CLKS_PER_BIT = 217,
  parameter int INSTR_BYTES  = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_rx_n_if.master bus
);

  localparam int IW       = 8 * INSTR_BYTES;
  localparam int CLK_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W    = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = (TO_LIMIT > 0) ? $clog2(TO_LIMIT + 1) : 1;
  localparam bit TO_EN    = (TIMEOUT_BITS > 0) && (INSTR_BYTES > 1);

  localparam logic [CLK_W-1:0] HALF_CNT = CLK_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CLK_W-1:0] BIT_CNT  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INSTR_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_CNT   = TO_W'(TO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_sync;
  logic [CLK_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_shift;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [IW-1:0]     asm_q;
  logic [IW-1:0]     asm_next;
  logic              start_det;
  logic              last_byte;

  assign start_det = (state == S_IDLE) && !rx_sync;
  assign last_byte = (byte_cnt == LAST_IDX);
  assign bus.o_busy = (state != S_IDLE) || (byte_cnt != '0);

  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) asm_next[8*i +: 8] = rx_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta           <= 1'b1;
      rx_sync           <= 1'b1;
      state             <= S_IDLE;
      clk_cnt           <= '0;
      bit_idx           <= '0;
      rx_shift          <= '0;
      byte_cnt          <= '0;
      to_cnt            <= '0;
      asm_q             <= '0;
      bus.o_byte_dv     <= 1'b0;
      bus.o_byte        <= '0;
      bus.o_instr_valid <= 1'b0;
      bus.o_instr       <= '0;
      bus.o_frame_err   <= 1'b0;
      bus.o_timeout     <= 1'b0;
      bus.o_overrun     <= 1'b0;
    end else begin
      rx_meta         <= bus.i_rx_serial;
      rx_sync         <= rx_meta;
      bus.o_byte_dv   <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_overrun   <= 1'b0;

      if (bus.o_instr_valid && bus.i_instr_ready) bus.o_instr_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == BIT_CNT) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (clk_cnt == BIT_CNT) begin
            clk_cnt <= '0;
            state   <= S_CLEANUP;
            if (rx_sync) begin
              bus.o_byte_dv <= 1'b1;
              bus.o_byte    <= rx_shift;
              if (last_byte) begin
                byte_cnt <= '0;
                // a consumer accepting this very cycle frees the slot in time
                if (!bus.o_instr_valid || bus.i_instr_ready) begin
                  bus.o_instr       <= asm_next;
                  bus.o_instr_valid <= 1'b1;
                end else begin
                  bus.o_overrun <= 1'b1;
                end
              end else begin
                asm_q    <= asm_next;
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              bus.o_frame_err <= 1'b1;
              byte_cnt        <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_CLEANUP: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase

      // start detection has priority over an expiring timeout
      if (byte_cnt == '0 || start_det) begin
        to_cnt <= '0;
      end else if (TO_EN && state == S_IDLE) begin
        if (to_cnt == TO_CNT) begin
          to_cnt        <= '0;
          byte_cnt      <= '0;
          bus.o_timeout <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
